// File: rtl/reg_file_pkg.sv
// Shared definitions for the parametrised register file: clear-FSM states and default sizes.
package reg_file_pkg;

  localparam int unsigned REG_WIDTH  = 8;
  localparam int unsigned REG_ADDR_W = 3;

  typedef enum logic {
    ST_IDLE,
    ST_CLEARING
  } clr_state_t;

endpackage

// File: rtl/reg_file_clear_fsm.sv
// Clear sweep controller: state, sweep pointer, BUSY/DROP and write qualification.
module reg_file_clear_fsm
  import reg_file_pkg::*;
#(
  parameter int unsigned ADDR_W = REG_ADDR_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CLEAR,
  input  logic              WRITE,
  output logic              BUSY,
  output logic              DROP,
  output logic              wr_en,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_idx
);

  clr_state_t        state, state_n;
  logic [ADDR_W-1:0] ptr, ptr_n;
  logic              busy_n, drop_n;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= ST_IDLE;
      ptr   <= '0;
      BUSY  <= 1'b0;
      DROP  <= 1'b0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      BUSY  <= busy_n;
      DROP  <= drop_n;
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    busy_n  = BUSY;
    drop_n  = 1'b0;
    wr_en   = 1'b0;
    clr_en  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (CLEAR) begin
          // CLEAR wins over a coincident write; the write is reported as dropped
          state_n = ST_CLEARING;
          ptr_n   = '0;
          busy_n  = 1'b1;
          drop_n  = WRITE;
        end else begin
          wr_en = WRITE;
        end
      end
      ST_CLEARING: begin
        clr_en = 1'b1;
        ptr_n  = ptr + 1'b1;
        drop_n = WRITE;
        if (ptr == '1) begin
          state_n = ST_IDLE;
          busy_n  = 1'b0;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign clr_idx = ptr;

endmodule

// File: rtl/reg_file_param.sv
// Parametrised 1W/2R register file with write bypass, optional zero register and clear sweep.
module reg_file_param
  import reg_file_pkg::*;
#(
  parameter int unsigned WIDTH     = REG_WIDTH,
  parameter int unsigned ADDR_W    = REG_ADDR_W,
  parameter int unsigned BYPASS    = 1,
  parameter int unsigned ZERO_REG0 = 0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              WRITE,
  input  logic [WIDTH-1:0]  IN,
  input  logic [ADDR_W-1:0] INADDRESS,
  input  logic [ADDR_W-1:0] OUT1ADDRESS,
  input  logic [ADDR_W-1:0] OUT2ADDRESS,
  output logic [WIDTH-1:0]  OUT1,
  output logic [WIDTH-1:0]  OUT2,
  input  logic              CLEAR,
  output logic              BUSY,
  output logic              DROP
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic              wr_en, clr_en, wr_keep;
  logic [ADDR_W-1:0] clr_idx;

  reg_file_clear_fsm #(.ADDR_W(ADDR_W)) u_clear_fsm (
    .CLK     (CLK),
    .RESET   (RESET),
    .CLEAR   (CLEAR),
    .WRITE   (WRITE),
    .BUSY    (BUSY),
    .DROP    (DROP),
    .wr_en   (wr_en),
    .clr_en  (clr_en),
    .clr_idx (clr_idx)
  );

  // Writes to a hardwired register 0 are discarded silently (no DROP)
  assign wr_keep = wr_en && !(ZERO_REG0 != 0 && INADDRESS == '0);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i[ADDR_W-1:0]] <= '0;
    end else if (clr_en) begin
      mem[clr_idx] <= '0;
    end else if (wr_keep) begin
      mem[INADDRESS] <= IN;
    end
  end

  always_comb begin
    OUT1 = mem[OUT1ADDRESS];
    if (BYPASS != 0 && wr_keep && INADDRESS == OUT1ADDRESS) OUT1 = IN;
    if (ZERO_REG0 != 0 && OUT1ADDRESS == '0) OUT1 = '0;
  end

  always_comb begin
    OUT2 = mem[OUT2ADDRESS];
    if (BYPASS != 0 && wr_keep && INADDRESS == OUT2ADDRESS) OUT2 = IN;
    if (ZERO_REG0 != 0 && OUT2ADDRESS == '0) OUT2 = '0;
  end

endmodule

// File: tb/tb_reg_file_param.sv
// Self-checking bench: a default instance and a ZERO_REG0 instance share all inputs and
// are compared against a register-array reference model.
module tb_reg_file_param;

  logic       CLK;
  logic       RESET;
  logic       WRITE;
  logic [7:0] IN;
  logic [2:0] INADDRESS, OUT1ADDRESS, OUT2ADDRESS;
  logic       CLEAR;
  logic [7:0] o1 [2];
  logic [7:0] o2 [2];
  logic       busy [2];
  logic       drop [2];

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: contents per instance, remaining sweep edges, expected DROP
  logic [7:0] m [2][8];
  int         rem;
  logic       mdrop;

  reg_file_param dut (
    .CLK(CLK), .RESET(RESET), .WRITE(WRITE), .IN(IN), .INADDRESS(INADDRESS),
    .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS), .OUT1(o1[0]), .OUT2(o2[0]),
    .CLEAR(CLEAR), .BUSY(busy[0]), .DROP(drop[0])
  );

  reg_file_param #(.ZERO_REG0(1)) dutz (
    .CLK(CLK), .RESET(RESET), .WRITE(WRITE), .IN(IN), .INADDRESS(INADDRESS),
    .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS), .OUT1(o1[1]), .OUT2(o2[1]),
    .CLEAR(CLEAR), .BUSY(busy[1]), .DROP(drop[1])
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_out(input int i, input logic [2:0] a);
    if (i == 1 && a == 3'd0) return 8'd0;
    if (WRITE && rem == 0 && !CLEAR && a == INADDRESS) return IN;
    return m[i][a];
  endfunction

  task automatic check_reads(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s.inst%0d.OUT1[%0d]", tag, i, OUT1ADDRESS), o1[i], exp_out(i, OUT1ADDRESS));
      chk($sformatf("%s.inst%0d.OUT2[%0d]", tag, i, OUT2ADDRESS), o2[i], exp_out(i, OUT2ADDRESS));
    end
  endtask

  task automatic check_flags(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s.inst%0d.BUSY", tag, i), {7'd0, busy[i]}, {7'd0, rem != 0});
      chk($sformatf("%s.inst%0d.DROP", tag, i), {7'd0, drop[i]}, {7'd0, mdrop});
    end
  endtask

  // One clock cycle: apply inputs, check combinational reads, clock, update model, recheck
  task automatic step(input string tag, input logic w, input logic [7:0] d,
                      input logic [2:0] wa, input logic [2:0] ra1, input logic [2:0] ra2,
                      input logic c);
    WRITE = w; IN = d; INADDRESS = wa; OUT1ADDRESS = ra1; OUT2ADDRESS = ra2; CLEAR = c;
    #1;
    check_reads({tag, ".pre"});
    @(posedge CLK);
    if (rem == 0) begin
      if (c) begin
        mdrop = w;
        rem   = 8;
      end else begin
        mdrop = 1'b0;
        if (w) begin
          m[0][wa] = d;
          if (wa != 3'd0) m[1][wa] = d;
        end
      end
    end else begin
      m[0][8 - rem] = 8'd0;
      m[1][8 - rem] = 8'd0;
      rem--;
      mdrop = w;
    end
    #1;
    check_flags({tag, ".post"});
    check_reads({tag, ".post"});
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < 8; a++) m[i][a] = 8'd0;
    rem   = 0;
    mdrop = 1'b0;
  endtask

  // Asserts reset away from the clock edge, checks its immediate effect, then releases it
  task automatic do_reset(input string tag);
    WRITE = 1'b0; CLEAR = 1'b0;
    RESET = 1'b0;
    #1;
    model_reset();
    check_flags(tag);
    for (int a = 0; a < 8; a++) begin
      OUT1ADDRESS = a[2:0];
      OUT2ADDRESS = 3'(7 - a);
      #1;
      check_reads(tag);
    end
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    #1;
  endtask

  initial begin
    RESET = 1'b0; WRITE = 1'b0; CLEAR = 1'b0; IN = '0;
    INADDRESS = '0; OUT1ADDRESS = '0; OUT2ADDRESS = '0;
    model_reset();
    @(posedge CLK);
    #1;
    do_reset("reset");

    step("rd37", 1'b0, 8'd0, 3'd0, 3'd3, 3'd7, 1'b0);

    step("wr3_byp", 1'b1, 8'd23, 3'd3, 3'd3, 3'd7, 1'b0);
    step("rd3", 1'b0, 8'd0, 3'd0, 3'd3, 3'd3, 1'b0);

    step("wr0", 1'b1, 8'd45, 3'd0, 3'd0, 3'd4, 1'b0);
    step("wr4", 1'b1, 8'd55, 3'd4, 3'd0, 3'd4, 1'b0);
    step("wr1", 1'b1, 8'd66, 3'd1, 3'd1, 3'd4, 1'b0);
    step("clr", 1'b0, 8'd0, 3'd0, 3'd0, 3'd4, 1'b1);
    step("busy1", 1'b0, 8'd0, 3'd0, 3'd0, 3'd1, 1'b1);
    step("busy2", 1'b0, 8'd0, 3'd0, 3'd1, 3'd4, 1'b0);
    step("busy3_wr", 1'b1, 8'd50, 3'd1, 3'd1, 3'd3, 1'b0);
    for (int k = 4; k <= 8; k++)
      step($sformatf("busy%0d", k), 1'b0, 8'd0, 3'd0, 3'd1, 3'd4, 1'b0);
    step("after_clr", 1'b0, 8'd0, 3'd0, 3'd0, 3'd4, 1'b0);
    step("after_clr1", 1'b0, 8'd0, 3'd0, 3'd1, 3'd3, 1'b0);

    step("wr5", 1'b1, 8'd77, 3'd5, 3'd5, 3'd2, 1'b0);
    step("clr_wr", 1'b1, 8'd27, 3'd2, 3'd2, 3'd5, 1'b1);
    for (int k = 1; k <= 3; k++)
      step($sformatf("sweep%0d", k), 1'b0, 8'd0, 3'd0, 3'd2, 3'd5, 1'b0);
    do_reset("reset_mid");

    step("z_wr0", 1'b1, 8'd99, 3'd0, 3'd0, 3'd0, 1'b0);
    step("z_rd0", 1'b0, 8'd0, 3'd0, 3'd0, 3'd0, 1'b0);

    step("clr_hold", 1'b0, 8'd0, 3'd0, 3'd0, 3'd1, 1'b1);
    for (int k = 0; k < 9; k++)
      step("clr_hold_sweep", 1'b0, 8'd0, 3'd0, 3'd0, 3'd1, 1'b1);
    step("clr_hold_end", 1'b0, 8'd0, 3'd0, 3'd0, 3'd1, 1'b0);
    while (rem != 0) step("drain", 1'b0, 8'd0, 3'd0, 3'd0, 3'd1, 1'b0);

    for (int k = 0; k < 400; k++)
      step("rand", 1'($urandom_range(0, 3) != 0), 8'($urandom),
           3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom_range(0, 24) == 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
